// File: rtl/vid_bbox_pkg.sv
// Shared types and constants for the bounding-box overlay stage.
package vid_bbox_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [10:0] coord_t;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;
  localparam coord_t     COORD_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VIDEO = 2'd1,
    ST_OTHER = 2'd2
  } parse_state_t;

  function automatic logic in_range(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vid_bbox_accum.sv
// Running min/max of matching pixel coordinates; latches the box at end of frame.
module vid_bbox_accum
  import vid_bbox_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   match,
  input  coord_t x,
  input  coord_t y,
  input  logic   eop,
  input  logic   clear,
  output coord_t bbox_x_min,
  output coord_t bbox_x_max,
  output coord_t bbox_y_min,
  output coord_t bbox_y_max,
  output logic   bbox_valid,
  output logic   frame_done
);

  coord_t x_lo, x_hi, y_lo, y_hi;
  coord_t x_lo_n, x_hi_n, y_lo_n, y_hi_n;
  logic   hit, hit_n;

  // The eop pixel itself must be folded in before latching, hence the lookahead.
  always_comb begin
    x_lo_n = x_lo;
    x_hi_n = x_hi;
    y_lo_n = y_lo;
    y_hi_n = y_hi;
    hit_n  = hit;
    if (match) begin
      if (x < x_lo) x_lo_n = x;
      if (x > x_hi) x_hi_n = x;
      if (y < y_lo) y_lo_n = y;
      if (y > y_hi) y_hi_n = y;
      hit_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lo       <= COORD_MAX;
      x_hi       <= '0;
      y_lo       <= COORD_MAX;
      y_hi       <= '0;
      hit        <= 1'b0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (eop) begin
        frame_done <= 1'b1;
        bbox_valid <= hit_n;
        if (hit_n) begin
          bbox_x_min <= x_lo_n;
          bbox_x_max <= x_hi_n;
          bbox_y_min <= y_lo_n;
          bbox_y_max <= y_hi_n;
        end
        x_lo <= COORD_MAX;
        x_hi <= '0;
        y_lo <= COORD_MAX;
        y_hi <= '0;
        hit  <= 1'b0;
      end else if (clear) begin
        x_lo <= COORD_MAX;
        x_hi <= '0;
        y_lo <= COORD_MAX;
        y_hi <= '0;
        hit  <= 1'b0;
      end else begin
        x_lo <= x_lo_n;
        x_hi <= x_hi_n;
        y_lo <= y_lo_n;
        y_hi <= y_hi_n;
        hit  <= hit_n;
      end
    end
  end

endmodule

// File: rtl/vid_bbox_overlay.sv
// Avalon-ST video stage: colour-window bounding box detection and outline overlay.
// Define VID_BBOX_CROSSHAIR_EN to also draw a crosshair through the box centre.
module vid_bbox_overlay
  import vid_bbox_pkg::*;
#(
  parameter int          IMG_W   = 640,
  parameter int          IMG_H   = 480,
  parameter logic [7:0]  R_MIN   = 8'd150,
  parameter logic [7:0]  R_MAX   = 8'd255,
  parameter logic [7:0]  G_MIN   = 8'd0,
  parameter logic [7:0]  G_MAX   = 8'd90,
  parameter logic [7:0]  B_MIN   = 8'd0,
  parameter logic [7:0]  B_MAX   = 8'd90,
  parameter logic [23:0] BOX_RGB = 24'h00FF00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [23:0]  sink_data,
  input  logic         sink_valid,
  input  logic         sink_sop,
  input  logic         sink_eop,
  output logic         sink_ready,
  output logic [23:0]  source_data,
  output logic         source_valid,
  output logic         source_sop,
  output logic         source_eop,
  input  logic         source_ready,
  input  logic         mode,
  output coord_t       bbox_x_min,
  output coord_t       bbox_x_max,
  output coord_t       bbox_y_min,
  output coord_t       bbox_y_max,
  output logic         bbox_valid,
  output logic         frame_done,
  output parse_state_t parse_state
);

  // Handshake: a beat moves when sink_valid && sink_ready; the output register
  // may only be overwritten when it is empty or being consumed this cycle.
  parse_state_t state, state_n;
  coord_t       x, y;
  rgb_t         pix;
  logic         xfer, pixel_beat, pix_match, on_edge, on_cross, overlay;

  assign sink_ready  = !source_valid || source_ready;
  assign xfer        = sink_valid && sink_ready;
  assign pix         = sink_data;
  assign pixel_beat  = xfer && !sink_sop && (state == ST_VIDEO);
  assign pix_match   = pixel_beat && (y < coord_t'(IMG_H)) &&
                       in_range(pix.r, R_MIN, R_MAX) &&
                       in_range(pix.g, G_MIN, G_MAX) &&
                       in_range(pix.b, B_MIN, B_MAX);
  assign parse_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // A sop always re-parses, which also recovers from truncated packets.
  always_comb begin
    state_n = state;
    if (xfer) begin
      if (sink_sop) begin
        if (sink_eop)                         state_n = ST_IDLE;
        else if (sink_data[3:0] == PKT_VIDEO) state_n = ST_VIDEO;
        else                                  state_n = ST_OTHER;
      end else if (sink_eop && (state != ST_IDLE)) begin
        state_n = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (xfer && sink_sop) begin
      x <= '0;
      y <= '0;
    end else if (pixel_beat) begin
      if (x == coord_t'(IMG_W - 1)) begin
        x <= '0;
        if (y != coord_t'(IMG_H)) y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  vid_bbox_accum u_accum (
    .clk        (clk),
    .reset      (reset),
    .match      (pix_match),
    .x          (x),
    .y          (y),
    .eop        (pixel_beat && sink_eop),
    .clear      (xfer && sink_sop),
    .bbox_x_min (bbox_x_min),
    .bbox_x_max (bbox_x_max),
    .bbox_y_min (bbox_y_min),
    .bbox_y_max (bbox_y_max),
    .bbox_valid (bbox_valid),
    .frame_done (frame_done)
  );

  assign on_edge = (((x == bbox_x_min) || (x == bbox_x_max)) &&
                    (y >= bbox_y_min) && (y <= bbox_y_max)) ||
                   (((y == bbox_y_min) || (y == bbox_y_max)) &&
                    (x >= bbox_x_min) && (x <= bbox_x_max));

`ifdef VID_BBOX_CROSSHAIR_EN
  logic [11:0] sum_x, sum_y;
  coord_t      cx, cy;
  assign sum_x    = {1'b0, bbox_x_min} + {1'b0, bbox_x_max};
  assign sum_y    = {1'b0, bbox_y_min} + {1'b0, bbox_y_max};
  assign cx       = sum_x[11:1];
  assign cy       = sum_y[11:1];
  assign on_cross = ((x == cx) && (y >= bbox_y_min) && (y <= bbox_y_max)) ||
                    ((y == cy) && (x >= bbox_x_min) && (x <= bbox_x_max));
`else
  assign on_cross = 1'b0;
`endif

  // The box registers only change after this frame's eop, so the drawn box lags one frame.
  assign overlay = pixel_beat && mode && bbox_valid && (on_edge || on_cross);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      source_data  <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else if (xfer) begin
      source_data  <= overlay ? BOX_RGB : sink_data;
      source_valid <= 1'b1;
      source_sop   <= sink_sop;
      source_eop   <= sink_eop;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_bbox_overlay.sv
// Directed bench for vid_bbox_overlay on a reduced 32x24 frame.
module tb_vid_bbox_overlay;

  localparam int W = 32;
  localparam int H = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] sink_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic [23:0] source_data;
  logic        source_valid, source_sop, source_eop;
  logic        source_ready;
  logic        mode;
  logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic        bbox_valid, frame_done;
  logic [1:0]  parse_state;

  int          errors = 0;
  int          checks = 0;
  logic [25:0] exp_q[$];
  logic [25:0] out_q[$];

  logic        m_valid;
  int          m_xmin, m_xmax, m_ymin, m_ymax;
  int          fd_cnt = 0;
  logic [10:0] fd_xmin, fd_xmax, fd_ymin, fd_ymax;
  logic        fd_valid;
  logic        stall_en = 1'b0;

  vid_bbox_overlay #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_ready   (sink_ready),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_ready (source_ready),
    .mode         (mode),
    .bbox_x_min   (bbox_x_min),
    .bbox_x_max   (bbox_x_max),
    .bbox_y_min   (bbox_y_min),
    .bbox_y_max   (bbox_y_max),
    .bbox_valid   (bbox_valid),
    .frame_done   (frame_done),
    .parse_state  (parse_state)
  );

  // clock / reset / environment
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always begin : ready_gen
    logic [3:0] pat;
    int sc;
    pat = 4'b1001;
    sc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_en) begin
        source_ready = pat[sc];
        sc = (sc + 1) % 4;
      end else begin
        source_ready = 1'b1;
        sc = 0;
      end
    end
  end

  always begin
    @(posedge clk);
    #8;
    if (source_valid === 1'b1 && source_ready === 1'b1)
      out_q.push_back({source_sop, source_eop, source_data});
  end

  always begin
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_xmin  = bbox_x_min;
      fd_xmax  = bbox_x_max;
      fd_ymin  = bbox_y_min;
      fd_ymax  = bbox_y_max;
      fd_valid = bbox_valid;
    end
  end

  // stimulus generators and reference overlay
  function automatic logic [23:0] gen_pix(input int pat, input int x, input int y);
    case (pat)
      1: return (x >= 10 && x <= 19 && y >= 5 && y <= 7) ? 24'hFF0000 : 24'h000000;
      2: return (x == 0 && y == 0) ? 24'hFF0000 : 24'h000000;
      3: return (x == 20 && y == 2) ? 24'hFF0000 : 24'h000000;
      4: begin
        if (x == 31 && y == 23) return 24'h965A5A;
        if (x == 5 && y == 24)  return 24'hFF0000;
        if (x == 0 && y == 0)   return 24'hC85B00;
        if (x == 1 && y == 0)   return 24'h950000;
        if (x == 2 && y == 0)   return 24'hFF005B;
        return 24'h000000;
      end
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] model_pix(input int x, input int y, input logic [23:0] p);
    logic on_box;
    if (!(mode && m_valid)) return p;
    on_box = ((x == m_xmin || x == m_xmax) && y >= m_ymin && y <= m_ymax) ||
             ((y == m_ymin || y == m_ymax) && x >= m_xmin && x <= m_xmax);
`ifdef VID_BBOX_CROSSHAIR_EN
    if ((x == (m_xmin + m_xmax) / 2 && y >= m_ymin && y <= m_ymax) ||
        (y == (m_ymin + m_ymax) / 2 && x >= m_xmin && x <= m_xmax)) on_box = 1'b1;
`endif
    return on_box ? 24'h00FF00 : p;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= out_q.size()) return i;
      if (out_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    int guard;
    @(negedge clk);
    sink_data  = d;
    sink_sop   = s;
    sink_eop   = e;
    sink_valid = 1'b1;
    #1;
    guard = 0;
    while (!sink_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!sink_ready) begin
      checks++;
      errors++;
      $display("FAIL send_beat: sink_ready got %b expected 1 within 200 cycles", sink_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int pat, input int npix, input logic do_eop);
    int x, y;
    logic [23:0] p;
    logic e;
    send_beat(24'h000000, 1'b1, 1'b0);
    exp_q.push_back({2'b10, 24'h000000});
    for (int i = 0; i < npix; i++) begin
      x = i % W;
      y = i / W;
      if (y > H) y = H;
      p = gen_pix(pat, x, y);
      e = do_eop && (i == npix - 1);
      send_beat(p, 1'b0, e);
      exp_q.push_back({1'b0, e, model_pix(x, y, p)});
    end
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic drain(output logic ok);
    int guard;
    guard = 0;
    while (out_q.size() < exp_q.size() && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    ok = (out_q.size() == exp_q.size());
  endtask

  task automatic start_test();
    exp_q.delete();
    out_q.delete();
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (source_valid !== 1'b0) begin errors++; $display("FAIL reset_source_valid: got %b expected 0", source_valid); end
    checks++;
    if (bbox_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got valid=%b done=%b expected 0 0", bbox_valid, frame_done);
    end
    checks++;
    if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} !== 44'd0) begin
      errors++; $display("FAIL reset_bbox: got %h expected 0", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max});
    end
    checks++;
    if (parse_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", parse_state); end
    @(posedge clk);
    #1;
    checks++;
    if (sink_ready !== 1'b1) begin errors++; $display("FAIL reset_sink_ready: got %b expected 1", sink_ready); end
  endtask

  task automatic test_detect();
    logic ok;
    int d, fd0;
    start_test();
    mode = 1'b1;
    m_valid = 1'b0;
    fd0 = fd_cnt;
    send_frame(1, W * H, 1'b1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL detect_count: got %0d beats expected %0d", out_q.size(), exp_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL detect_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL detect_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    checks++;
    if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid} !== {11'd10, 11'd19, 11'd5, 11'd7, 1'b1}) begin
      errors++; $display("FAIL detect_box: got %0d %0d %0d %0d v=%b expected 10 19 5 7 v=1",
                         bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid);
    end
    checks++;
    if ({fd_xmin, fd_xmax, fd_ymin, fd_ymax, fd_valid} !== {11'd10, 11'd19, 11'd5, 11'd7, 1'b1}) begin
      errors++; $display("FAIL detect_box_at_pulse: got %0d %0d %0d %0d v=%b expected 10 19 5 7 v=1",
                         fd_xmin, fd_xmax, fd_ymin, fd_ymax, fd_valid);
    end
    m_valid = 1'b1; m_xmin = 10; m_xmax = 19; m_ymin = 5; m_ymax = 7;
  endtask

  task automatic test_overlay();
    logic ok;
    int d, fd0;
    logic [23:0] centre_exp;
`ifdef VID_BBOX_CROSSHAIR_EN
    centre_exp = 24'h00FF00;
`else
    centre_exp = 24'hFF0000;
`endif
    start_test();
    mode = 1'b1;
    fd0 = fd_cnt;
    send_frame(1, W * H, 1'b1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overlay_count: got %0d beats expected %0d", out_q.size(), exp_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL overlay_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (out_q[1 + 6 * W + 10] !== {2'b00, 24'h00FF00}) begin
      errors++; $display("FAIL overlay_left_edge: got %h expected 00FF00", out_q[1 + 6 * W + 10]);
    end
    checks++;
    if (out_q[1 + 5 * W + 15] !== {2'b00, 24'h00FF00}) begin
      errors++; $display("FAIL overlay_top_edge: got %h expected 00FF00", out_q[1 + 5 * W + 15]);
    end
    checks++;
    if (out_q[1 + 6 * W + 15] !== {2'b00, centre_exp}) begin
      errors++; $display("FAIL overlay_inside: got %h expected %h", out_q[1 + 6 * W + 15], centre_exp);
    end
    checks++;
    if (fd_cnt != fd0 + 1 || bbox_x_min !== 11'd10 || bbox_y_max !== 11'd7) begin
      errors++; $display("FAIL overlay_result: got pulses=%0d xmin=%0d ymax=%0d expected 1 10 7",
                         fd_cnt - fd0, bbox_x_min, bbox_y_max);
    end
  endtask

  task automatic test_ctrl();
    logic ok;
    int d, fd0;
    start_test();
    fd0 = fd_cnt;
    send_beat(24'h00000F, 1'b1, 1'b0); exp_q.push_back({2'b10, 24'h00000F});
    send_beat(24'h123456, 1'b0, 1'b0); exp_q.push_back({2'b00, 24'h123456});
    send_beat(24'h123456, 1'b0, 1'b0); exp_q.push_back({2'b00, 24'h123456});
    send_beat(24'h123456, 1'b0, 1'b1); exp_q.push_back({2'b01, 24'h123456});
    @(negedge clk);
    sink_valid = 1'b0; sink_eop = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ctrl_count: got %0d beats expected 4", out_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL ctrl_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0) begin errors++; $display("FAIL ctrl_no_frame_done: got %0d pulses expected 0", fd_cnt - fd0); end
    checks++;
    if (parse_state !== 2'd0) begin errors++; $display("FAIL ctrl_state_idle: got %0d expected 0", parse_state); end
  endtask

  task automatic test_stall();
    logic ok;
    int d, fd0;
    start_test();
    mode = 1'b1;
    stall_en = 1'b1;
    fd0 = fd_cnt;
    send_frame(1, W * H, 1'b1);
    drain(ok);
    stall_en = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_count: got %0d beats expected %0d", out_q.size(), exp_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL stall_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL stall_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
  endtask

  task automatic test_no_match();
    logic ok;
    int d, fd0;
    start_test();
    mode = 1'b1;
    fd0 = fd_cnt;
    send_frame(0, W * H, 1'b1);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nomatch_count: got %0d beats expected %0d", out_q.size(), exp_q.size()); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL nomatch_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0 + 1 || bbox_valid !== 1'b0) begin
      errors++; $display("FAIL nomatch_valid: got pulses=%0d valid=%b expected 1 0", fd_cnt - fd0, bbox_valid);
    end
    checks++;
    if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max} !== {11'd10, 11'd19, 11'd5, 11'd7}) begin
      errors++; $display("FAIL nomatch_hold: got %0d %0d %0d %0d expected 10 19 5 7",
                         bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max);
    end
    m_valid = 1'b0;
    start_test();
    send_frame(0, W * H, 1'b1);
    drain(ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL nomatch_no_overlay: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (out_q[1 + 6 * W + 10] !== {2'b00, 24'h000000}) begin
      errors++; $display("FAIL nomatch_edge_pixel: got %h expected 000000", out_q[1 + 6 * W + 10]);
    end
  endtask

  task automatic test_truncate();
    logic ok;
    int d, fd0;
    start_test();
    mode = 1'b0;
    fd0 = fd_cnt;
    send_frame(3, 100, 1'b0);
    send_frame(2, W * H, 1'b1);
    drain(ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL trunc_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL trunc_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    checks++;
    if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid} !== {44'd0, 1'b1}) begin
      errors++; $display("FAIL trunc_box: got %0d %0d %0d %0d v=%b expected 0 0 0 0 v=1",
                         bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid);
    end
  endtask

  task automatic test_overflow_lines();
    logic ok;
    int d, fd0;
    start_test();
    mode = 1'b0;
    fd0 = fd_cnt;
    send_frame(4, W * (H + 1), 1'b1);
    drain(ok);
    d = first_diff();
    checks++;
    if (!ok || d != -1) begin errors++; $display("FAIL extra_line_stream: beat %0d got %h expected %h", d, out_q[d], exp_q[d]); end
    checks++;
    if (fd_cnt != fd0 + 1) begin errors++; $display("FAIL extra_line_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    checks++;
    if ({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid} !== {11'd31, 11'd31, 11'd23, 11'd23, 1'b1}) begin
      errors++; $display("FAIL extra_line_box: got %0d %0d %0d %0d v=%b expected 31 31 23 23 v=1",
                         bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid);
    end
  endtask

  initial begin
    reset      = 1'b1;
    sink_data  = '0;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    source_ready = 1'b1;
    mode       = 1'b0;
    m_valid    = 1'b0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_detect();
    test_overlay();
    test_ctrl();
    test_stall();
    test_no_match();
    test_truncate();
    test_overflow_lines();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
